// File: rtl/ddram_pkg.sv
// ddram_pkg: shared widths, FSM state type and helpers for the DDRAM Avalon bridge.
// Optional feature macro used by this codebase slice: DDRAM_BRIDGE_WDOG_EN.
package ddram_pkg;

    localparam int DDR_ADDR_W  = 29;
    localparam int DDR_DATA_W  = 64;
    localparam int DDR_BE_W    = 8;
    localparam int DDR_BURST_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_CMD  = 2'd3
    } ddr_bridge_state_t;

    // A zero-length burst is meaningless on Avalon; treat it as a single word.
    function automatic logic [DDR_BURST_W-1:0] burst_coerce(input logic [DDR_BURST_W-1:0] b);
        return (b == '0) ? DDR_BURST_W'(1) : b;
    endfunction

endpackage

// File: rtl/ddram_avl_bridge_if.sv
// ddram_avl_bridge_if: arbiter-side dc_* request bus plus the MiSTer DDRAM Avalon pins.
// Handshakes: dc_rd_req / dc_wr_req are level requests held by the requestor until the
// matching dc_*_ack pulse; the ack is the cycle the Avalon command is taken
// (command asserted and DDRAM_BUSY low). dc_rd_data_valid pulses once per read word
// and has no back-pressure. DDRAM_RD / DDRAM_WE with address/data stay stable while
// DDRAM_BUSY (waitrequest) is high.
// The slave modport is the bridge view; master is the arbiter + memory view.
interface ddram_avl_bridge_if;
    import ddram_pkg::*;

    // arbiter side
    logic [DDR_ADDR_W-1:0]  dc_rd_addr;
    logic [DDR_BURST_W-1:0] dc_rd_burstcnt;
    logic                   dc_rd_req;
    logic                   dc_rd_ack;
    logic [DDR_DATA_W-1:0]  dc_rd_data;
    logic                   dc_rd_data_valid;
    logic [DDR_ADDR_W-1:0]  dc_wr_addr;
    logic [DDR_BURST_W-1:0] dc_wr_burstcnt;
    logic [DDR_DATA_W-1:0]  dc_wr_data;
    logic [DDR_BE_W-1:0]    dc_wr_be;
    logic                   dc_wr_req;
    logic                   dc_wr_ack;
    logic                   dc_wr_busy;

    // DDRAM Avalon side
    logic                   DDRAM_BUSY;
    logic [DDR_BURST_W-1:0] DDRAM_BURSTCNT;
    logic [DDR_ADDR_W-1:0]  DDRAM_ADDR;
    logic [DDR_DATA_W-1:0]  DDRAM_DOUT;
    logic                   DDRAM_DOUT_READY;
    logic                   DDRAM_RD;
    logic [DDR_DATA_W-1:0]  DDRAM_DIN;
    logic [DDR_BE_W-1:0]    DDRAM_BE;
    logic                   DDRAM_WE;

    modport slave (
        input  dc_rd_addr, dc_rd_burstcnt, dc_rd_req,
        input  dc_wr_addr, dc_wr_burstcnt, dc_wr_data, dc_wr_be, dc_wr_req,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output dc_rd_ack, dc_rd_data, dc_rd_data_valid,
        output dc_wr_ack, dc_wr_busy,
        output DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

    modport master (
        output dc_rd_addr, dc_rd_burstcnt, dc_rd_req,
        output dc_wr_addr, dc_wr_burstcnt, dc_wr_data, dc_wr_be, dc_wr_req,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  dc_rd_ack, dc_rd_data, dc_rd_data_valid,
        input  dc_wr_ack, dc_wr_busy,
        input  DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_RD, DDRAM_DIN, DDRAM_BE, DDRAM_WE
    );

endinterface

// File: rtl/ddram_bridge_wdog.sv
// ddram_bridge_wdog: read-data watchdog for the DDRAM bridge (used under DDRAM_BRIDGE_WDOG_EN).
// Counts cycles spent waiting in RD_DATA without a returned word; the timeout pulse
// lands in the WDOG_CYCLES-th consecutive silent cycle and sets a sticky error.
module ddram_bridge_wdog #(
    parameter int unsigned WDOG_CYCLES = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic in_rd_data,
    input  logic rd_entry,
    input  logic dout_ready,
    output logic timeout,
    output logic err
);

    logic [15:0] count;

    assign timeout = in_rd_data && !dout_ready && (count == 16'(WDOG_CYCLES - 1));

    // Silence counter: cleared on entry, on each returned word and outside RD_DATA.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (rd_entry || dout_ready || !in_rd_data) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    // Sticky error flag, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (timeout) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/ddram_avl_bridge.sv
// ddram_avl_bridge: turns dc_* read/write requests into single Avalon-MM bursts on
// the MiSTer DDRAM port, one transaction in flight. Reads win over writes.
// Optional watchdog on read data: define DDRAM_BRIDGE_WDOG_EN.
module ddram_avl_bridge
    import ddram_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 4095
) (
    input  logic              clk,
    input  logic              reset,
    ddram_avl_bridge_if.slave bus,
    output logic              err,
    output ddr_bridge_state_t state_dbg
);

    ddr_bridge_state_t      state;
    logic [DDR_BURST_W-1:0] remain;
    logic                   ddram_rd_q;
    logic                   ddram_we_q;
    logic [DDR_ADDR_W-1:0]  ddram_addr_q;
    logic [DDR_DATA_W-1:0]  ddram_din_q;
    logic [DDR_BE_W-1:0]    ddram_be_q;
    logic [DDR_BURST_W-1:0] ddram_burstcnt_q;

    logic rd_cmd_taken;
    logic wr_cmd_taken;
    logic wdog_timeout;

    assign rd_cmd_taken = (state == RD_CMD) && !bus.DDRAM_BUSY;
    assign wr_cmd_taken = (state == WR_CMD) && !bus.DDRAM_BUSY;

    // Acks are combinational so the requestor sees them in the command-accept cycle.
    assign bus.dc_rd_ack        = rd_cmd_taken;
    assign bus.dc_wr_ack        = wr_cmd_taken;
    assign bus.dc_rd_data       = bus.DDRAM_DOUT;
    assign bus.dc_rd_data_valid = bus.DDRAM_DOUT_READY && (state == RD_DATA);
    assign bus.dc_wr_busy       = (state != IDLE);

    assign bus.DDRAM_RD       = ddram_rd_q;
    assign bus.DDRAM_WE       = ddram_we_q;
    assign bus.DDRAM_ADDR     = ddram_addr_q;
    assign bus.DDRAM_DIN      = ddram_din_q;
    assign bus.DDRAM_BE       = ddram_be_q;
    assign bus.DDRAM_BURSTCNT = ddram_burstcnt_q;

    assign state_dbg = state;

    // Writes are always single-word, so the requested write burst length is dropped.
    logic unused_wr_burstcnt;
    assign unused_wr_burstcnt = ^bus.dc_wr_burstcnt;

`ifdef DDRAM_BRIDGE_WDOG_EN
    ddram_bridge_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk        (clk),
        .reset      (reset),
        .in_rd_data (state == RD_DATA),
        .rd_entry   (rd_cmd_taken),
        .dout_ready (bus.DDRAM_DOUT_READY),
        .timeout    (wdog_timeout),
        .err        (err)
    );
`else
    // Without the watchdog RD_DATA waits forever and no error can be raised.
    // The limit stays a parameter so both builds share one instantiation.
    logic [15:0] unused_wdog_cycles;
    assign unused_wdog_cycles = 16'(WDOG_CYCLES);
    assign wdog_timeout       = 1'b0;
    assign err                = 1'b0;
`endif

    // Main FSM: latches the request, drives the Avalon command and tracks the burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            remain           <= '0;
            ddram_rd_q       <= 1'b0;
            ddram_we_q       <= 1'b0;
            ddram_addr_q     <= '0;
            ddram_din_q      <= '0;
            ddram_be_q       <= '0;
            ddram_burstcnt_q <= DDR_BURST_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dc_rd_req) begin
                        ddram_addr_q     <= bus.dc_rd_addr;
                        ddram_burstcnt_q <= burst_coerce(bus.dc_rd_burstcnt);
                        remain           <= burst_coerce(bus.dc_rd_burstcnt);
                        ddram_rd_q       <= 1'b1;
                        state            <= RD_CMD;
                    end else if (bus.dc_wr_req) begin
                        ddram_addr_q     <= bus.dc_wr_addr;
                        ddram_din_q      <= bus.dc_wr_data;
                        ddram_be_q       <= bus.dc_wr_be;
                        ddram_burstcnt_q <= DDR_BURST_W'(1);
                        ddram_we_q       <= 1'b1;
                        state            <= WR_CMD;
                    end
                end
                RD_CMD: begin
                    if (!bus.DDRAM_BUSY) begin
                        ddram_rd_q <= 1'b0;
                        state      <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (wdog_timeout) begin
                        // Abandon the burst; missing words are not fabricated.
                        state <= IDLE;
                    end else if (bus.DDRAM_DOUT_READY) begin
                        remain <= remain - DDR_BURST_W'(1);
                        if (remain == DDR_BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                WR_CMD: begin
                    if (!bus.DDRAM_BUSY) begin
                        ddram_we_q <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_avl_bridge.sv
// tb_ddram_avl_bridge: directed bench for ddram_avl_bridge with a read-data and
// write-command scoreboard fed by the stimulus and drained by a negedge monitor.
module tb_ddram_avl_bridge;
    import ddram_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              err;
    ddr_bridge_state_t state_dbg;

    ddram_avl_bridge_if bus();

    ddram_avl_bridge #(
        .WDOG_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "time limit");
    end

    int checks = 0;
    int errors = 0;
    int rd_ack_cnt = 0;
    int wr_ack_cnt = 0;
    logic [63:0]  rd_exp_q[$];
    logic [108:0] wr_exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One returned DDR word, valid for exactly one cycle.
    task automatic deliver(input logic [63:0] d, input bit expect_valid);
        if (expect_valid) rd_exp_q.push_back(d);
        bus.DDRAM_DOUT       = d;
        bus.DDRAM_DOUT_READY = 1'b1;
        step();
        bus.DDRAM_DOUT_READY = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [63:0]  e;
        logic [108:0] w;
        if (!reset && bus.dc_rd_data_valid) begin
            if (rd_exp_q.size() == 0) begin
                chk("rd_unexpected_valid", bus.dc_rd_data, 128'h0);
                if (bus.dc_rd_data == 64'h0) begin
                    errors++;
                    $display("FAIL rd_unexpected_valid act=valid exp=none");
                end
            end else begin
                e = rd_exp_q.pop_front();
                chk("rd_data", bus.dc_rd_data, e);
            end
        end
        if (bus.dc_rd_ack) rd_ack_cnt++;
        if (bus.dc_wr_ack) begin
            wr_ack_cnt++;
            if (wr_exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected_ack act=ack exp=none");
            end else begin
                w = wr_exp_q.pop_front();
                chk("wr_cmd", {bus.DDRAM_WE, bus.DDRAM_ADDR, bus.DDRAM_DIN, bus.DDRAM_BE, bus.DDRAM_BURSTCNT},
                    {1'b1, w});
            end
        end
    end

    int n;

    initial begin
        bus.dc_rd_addr = '0; bus.dc_rd_burstcnt = '0; bus.dc_rd_req = 1'b0;
        bus.dc_wr_addr = '0; bus.dc_wr_burstcnt = '0; bus.dc_wr_data = '0;
        bus.dc_wr_be = '0; bus.dc_wr_req = 1'b0;
        bus.DDRAM_BUSY = 1'b0; bus.DDRAM_DOUT = '0; bus.DDRAM_DOUT_READY = 1'b0;

        // reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_state", state_dbg, IDLE);
        chk("rst_rd_we", {bus.DDRAM_RD, bus.DDRAM_WE}, 2'b00);
        chk("rst_addr_din_be", {bus.DDRAM_ADDR, bus.DDRAM_DIN, bus.DDRAM_BE}, 0);
        chk("rst_burstcnt", bus.DDRAM_BURSTCNT, 1);
        chk("rst_dc_outs", {bus.dc_rd_ack, bus.dc_rd_data_valid, bus.dc_wr_ack, bus.dc_wr_busy, err}, 0);
        step();
        reset = 1'b0;

        // read 0x0001000 x4, no waitrequest
        step();
        bus.dc_rd_addr = 29'h0001000; bus.dc_rd_burstcnt = 8'd4; bus.dc_rd_req = 1'b1;
        @(negedge clk);
        chk("t1_idle_no_ack", bus.dc_rd_ack, 0);
        step();
        @(negedge clk);
        chk("t1_rd", bus.DDRAM_RD, 1);
        chk("t1_addr", bus.DDRAM_ADDR, 29'h0001000);
        chk("t1_bcnt", bus.DDRAM_BURSTCNT, 4);
        chk("t1_ack_cycle1", bus.dc_rd_ack, 1);
        step();
        bus.dc_rd_req = 1'b0;
        @(negedge clk);
        chk("t1_rd_one_cycle", bus.DDRAM_RD, 0);
        chk("t1_state_rd_data", state_dbg, RD_DATA);
        step();
        deliver(64'h1111_0000_0000_0001, 1'b1);
        step();
        deliver(64'h2222_0000_0000_0002, 1'b1);
        deliver(64'h3333_0000_0000_0003, 1'b1);
        deliver(64'h4444_0000_0000_0004, 1'b1);
        @(negedge clk);
        chk("t1_back_idle", state_dbg, IDLE);
        chk("t1_all_words", rd_exp_q.size(), 0);
        chk("t1_ack_count", rd_ack_cnt, 1);

        // read with waitrequest high for 3 cycles
        step();
        bus.dc_rd_addr = 29'h0ABCDEF; bus.dc_rd_burstcnt = 8'd2; bus.dc_rd_req = 1'b1;
        bus.DDRAM_BUSY = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_rd_hold", bus.DDRAM_RD, 1);
            chk("t2_addr_hold", bus.DDRAM_ADDR, 29'h0ABCDEF);
            chk("t2_no_ack_busy", bus.dc_rd_ack, 0);
            step();
        end
        bus.DDRAM_BUSY = 1'b0;
        @(negedge clk);
        chk("t2_rd_4th", {bus.DDRAM_RD, bus.DDRAM_ADDR}, {1'b1, 29'h0ABCDEF});
        chk("t2_ack_4th", bus.dc_rd_ack, 1);
        step();
        bus.dc_rd_req = 1'b0;
        deliver(64'hA5A5_A5A5_0000_0010, 1'b1);
        deliver(64'h5A5A_5A5A_0000_0020, 1'b1);

        // back-to-back: new read plus a write, raised the cycle after the last word
        bus.dc_rd_addr = 29'h0000200; bus.dc_rd_burstcnt = 8'd1; bus.dc_rd_req = 1'b1;
        bus.dc_wr_addr = 29'h1234567; bus.dc_wr_data = 64'hDEAD_BEEF_0123_4567;
        bus.dc_wr_be = 8'hF0; bus.dc_wr_burstcnt = 8'd7; bus.dc_wr_req = 1'b1;
        wr_exp_q.push_back({29'h1234567, 64'hDEAD_BEEF_0123_4567, 8'hF0, 8'd1});
        @(negedge clk);
        chk("t2_idle_after_last", state_dbg, IDLE);
        chk("t2_ack_count", rd_ack_cnt, 2);
        step();
        @(negedge clk);
        chk("t3_read_wins", state_dbg, RD_CMD);
        chk("t3_no_we", bus.DDRAM_WE, 0);
        chk("t3_no_wr_ack", bus.dc_wr_ack, 0);
        step();
        bus.dc_rd_req = 1'b0;
        deliver(64'h5555_6666_7777_8888, 1'b1);
        @(negedge clk);
        chk("t3_idle_wr_pending", state_dbg, IDLE);
        step();
        @(negedge clk);
        chk("t3_we", bus.DDRAM_WE, 1);
        chk("t3_bcnt_1", bus.DDRAM_BURSTCNT, 1);
        chk("t3_be", bus.DDRAM_BE, 8'hF0);
        chk("t3_wr_ack", bus.dc_wr_ack, 1);
        step();
        bus.dc_wr_req = 1'b0;
        @(negedge clk);
        chk("t3_done", {state_dbg, bus.DDRAM_WE, bus.dc_wr_busy}, {IDLE, 1'b0, 1'b0});
        chk("t3_wr_ack_once", wr_ack_cnt, 1);
        chk("t3_rd_words", rd_exp_q.size(), 0);

        // reset after 2 of 8 words
        step();
        bus.dc_rd_addr = 29'h0003000; bus.dc_rd_burstcnt = 8'd8; bus.dc_rd_req = 1'b1;
        step();
        step();
        bus.dc_rd_req = 1'b0;
        deliver(64'hC0DE_0000_0000_0001, 1'b1);
        deliver(64'hC0DE_0000_0000_0002, 1'b1);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("t4_rst_state", state_dbg, IDLE);
        chk("t4_rst_cmds", {bus.DDRAM_RD, bus.DDRAM_WE, bus.DDRAM_ADDR, bus.DDRAM_BE}, 0);
        chk("t4_rst_bcnt", bus.DDRAM_BURSTCNT, 1);
        chk("t4_rst_busy", bus.dc_wr_busy, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) deliver(64'hBAD0_0000_0000_0000 | 64'(i), 1'b0);
        @(negedge clk);
        chk("t4_late_dropped", {state_dbg, 32'(rd_exp_q.size())}, {IDLE, 32'd0});

        // burst count 0 coerced to 1
        step();
        bus.dc_rd_addr = 29'h1FFFFFFF; bus.dc_rd_burstcnt = 8'd0; bus.dc_rd_req = 1'b1;
        step();
        @(negedge clk);
        chk("t5_bcnt_coerced", bus.DDRAM_BURSTCNT, 1);
        chk("t5_addr_max", bus.DDRAM_ADDR, 29'h1FFFFFFF);
        step();
        bus.dc_rd_req = 1'b0;
        deliver(64'h0F0F_0F0F_F0F0_F0F0, 1'b1);
        @(negedge clk);
        chk("t5_idle_after_one", state_dbg, IDLE);
        step();
        deliver(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        @(negedge clk);
        chk("t5_stray_idle", {state_dbg, 32'(rd_exp_q.size())}, {IDLE, 32'd0});

        // burst 255
        step();
        bus.dc_rd_addr = 29'h0000400; bus.dc_rd_burstcnt = 8'd255; bus.dc_rd_req = 1'b1;
        step();
        step();
        bus.dc_rd_req = 1'b0;
        for (int i = 0; i < 255; i++) begin
            if (i == 254) begin
                @(negedge clk);
                chk("t6_waiting_last", state_dbg, RD_DATA);
                step();
            end
            deliver(64'h0101_0101_0101_0101 * 64'(i + 1), 1'b1);
        end
        @(negedge clk);
        chk("t6_idle_after_255", state_dbg, IDLE);
        chk("t6_all_words", rd_exp_q.size(), 0);

        // write held under waitrequest for 2 cycles
        step();
        bus.dc_wr_addr = 29'h0000ABC; bus.dc_wr_data = 64'h0123_4567_89AB_CDEF;
        bus.dc_wr_be = 8'h0F; bus.dc_wr_req = 1'b1; bus.DDRAM_BUSY = 1'b1;
        wr_exp_q.push_back({29'h0000ABC, 64'h0123_4567_89AB_CDEF, 8'h0F, 8'd1});
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t7_we_hold", {bus.DDRAM_WE, bus.dc_wr_ack}, 2'b10);
            step();
        end
        bus.DDRAM_BUSY = 1'b0;
        @(negedge clk);
        chk("t7_wr_ack", bus.dc_wr_ack, 1);
        step();
        bus.dc_wr_req = 1'b0;
        @(negedge clk);
        chk("t7_done", {state_dbg, 32'(wr_ack_cnt)}, {IDLE, 32'd2});

        // read whose data never arrives
        step();
        bus.dc_rd_addr = 29'h0000800; bus.dc_rd_burstcnt = 8'd4; bus.dc_rd_req = 1'b1;
        step();
        step();
        bus.dc_rd_req = 1'b0;
        n = 0;
        while (state_dbg != IDLE && n < 40) begin
            step();
            n++;
        end
        @(negedge clk);
`ifdef DDRAM_BRIDGE_WDOG_EN
        chk("wdog_cycles", n, 16);
        chk("wdog_err", err, 1);
        chk("wdog_idle_busy", {state_dbg, bus.dc_wr_busy}, {IDLE, 1'b0});
        step();
        step();
        @(negedge clk);
        chk("wdog_err_sticky", err, 1);
`else
        chk("nowdog_waits", {32'(n), state_dbg}, {32'd40, RD_DATA});
        chk("nowdog_err_zero", err, 0);
`endif
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("final_rst", {state_dbg, err, bus.dc_wr_busy}, {IDLE, 1'b0, 1'b0});

        // report
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddram_avl_bridge.md
# ddram_avl_bridge

Responder at the downstream end of the DDR3 request path. It accepts the single multiplexed `dc_*` read and write request interface driven by the DDR3 arbiter, and converts each request into one Avalon-MM burst on the MiSTer DDRAM port. It returns read data, acks and busy status on that same interface. It sits between the arbiter and the top-level DDRAM pins, with one transaction in flight at a time.

## Interface
Parameters:
- `WDOG_CYCLES`, default 4095: read-data watchdog limit in cycles. Used only when `DDRAM_BRIDGE_WDOG_EN` is defined.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `dc_rd_addr` in 29: read word address.
- `dc_rd_burstcnt` in 8: read burst length in 64-bit words.
- `dc_rd_req` in 1: level request, held until `dc_rd_ack`.
- `dc_rd_ack` out 1: read command accepted.
- `dc_rd_data` out 64: read data.
- `dc_rd_data_valid` out 1: one pulse per returned word.
- `dc_wr_addr` in 29: write word address.
- `dc_wr_burstcnt` in 8: ignored; writes are always single-word.
- `dc_wr_data` in 64: write data.
- `dc_wr_be` in 8: write byte enables.
- `dc_wr_req` in 1: level request, held until `dc_wr_ack`.
- `dc_wr_ack` out 1: write accepted.
- `dc_wr_busy` out 1: bridge not idle.
- `DDRAM_BUSY` in 1: Avalon waitrequest.
- `DDRAM_BURSTCNT` out 8: burst count.
- `DDRAM_ADDR` out 29: address.
- `DDRAM_DOUT` in 64: read data.
- `DDRAM_DOUT_READY` in 1: read data valid.
- `DDRAM_RD` out 1: read command.
- `DDRAM_DIN` out 64: write data.
- `DDRAM_BE` out 8: byte enables.
- `DDRAM_WE` out 1: write command.
- `err` out 1: sticky watchdog error.

## Operation
- FSM states: `IDLE`, `RD_CMD`, `RD_DATA`, `WR_CMD`.
- `IDLE` with `dc_rd_req`:
  - Latch address and burstcnt into `DDRAM_ADDR`/`DDRAM_BURSTCNT`.
  - Burstcnt 0 is coerced to 1.
  - Load `remain` with the same value; go to `RD_CMD`.
- `IDLE` with `dc_wr_req` and no `dc_rd_req`:
  - Latch addr, data and be; set `DDRAM_BURSTCNT`=1; go to `WR_CMD`.
- Simultaneous rd and wr requests: read wins; the write stays pending.
- `RD_CMD`:
  - `DDRAM_RD`=1 and the address is held stable while `DDRAM_BUSY`=1.
  - On `!DDRAM_BUSY`: `dc_rd_ack`=1 combinationally that cycle; go to `RD_DATA`.
- `RD_DATA`: each `DDRAM_DOUT_READY` gives `dc_rd_data_valid`=1 and decrements `remain`.
  - With `remain`==1 and ready → `IDLE`.
- `WR_CMD`:
  - `DDRAM_WE`=1 held under busy.
  - On `!DDRAM_BUSY`: `dc_wr_ack`=1 combinationally; go to `IDLE`.
- `dc_rd_data` = `DDRAM_DOUT`, passthrough.
- `dc_rd_data_valid` = `DDRAM_DOUT_READY` && state==`RD_DATA`. Stray data in other states is dropped.
- `dc_wr_busy` = state != `IDLE`.
- `remain` is 8 bits. Burst 255 decrements correctly; there is no wrap.

## Timing
- Reset values:
  - State `IDLE`.
  - `DDRAM_RD`/`DDRAM_WE`=0, `DDRAM_ADDR`/`DDRAM_DIN`=0, `DDRAM_BE`=0, `DDRAM_BURSTCNT`=1.
  - `remain`=0 and `err`=0.
  - All `dc_*` outputs 0.
- Read, request at cycle 0 in `IDLE`:
  - `DDRAM_RD` high at cycle 1.
  - With `BUSY`=0, `dc_rd_ack` at cycle 1.
  - Data valid follows `DOUT_READY` with 0-cycle latency.
- Write, request at cycle 0:
  - `DDRAM_WE` and `dc_wr_ack` at cycle 1 (busy low); `IDLE` at cycle 2.
  - The next request can be accepted at cycle 2. The requestor has deasserted by then, so there is no double issue.
- Back-to-back reads: the next read is accepted the cycle after the last data word.
- Reset mid-burst:
  - Return to `IDLE` immediately and drop commands.
  - Remaining DDR data arriving afterwards is suppressed because the state is `IDLE`.

## Configuration
- `DDRAM_BRIDGE_WDOG_EN` defined:
  - A 16-bit counter clears on every `DOUT_READY` and on entry to `RD_DATA`, and counts each cycle in `RD_DATA`.
  - When it reaches `WDOG_CYCLES`: set `err` (sticky until reset) and force the FSM to `IDLE`.
  - Remaining words are not synthesized.
- Not defined: `err` is tied 0; no counter logic; `RD_DATA` waits indefinitely.

## Structure
- Package `ddram_pkg`:
  - Constants `DDR_ADDR_W`=29, `DDR_DATA_W`=64, `DDR_BE_W`=8, `DDR_BURST_W`=8.
  - Enum `ddr_bridge_state_t`.
- Optional sub-module `ddram_bridge_wdog` (counter + sticky flag), instantiated only under the macro.

## Test plan
- Read addr 0x0001000, burstcnt 4, `BUSY` low → `DDRAM_RD` 1 cycle, `dc_rd_ack` at cycle 1, exactly 4 `dc_rd_data_valid` matching `DOUT`, then `IDLE`.
- Read with `DDRAM_BUSY` high 3 cycles → `DDRAM_RD`/`ADDR` stable 4 cycles; single `dc_rd_ack` on the 4th.
- Simultaneous rd and wr requests → read completes first. The write then issues with `DDRAM_BURSTCNT`=1, `BE`=0xF0, and `dc_wr_ack` once.
- Reset asserted after 2 of 8 words → outputs return to reset values; the 6 late `DOUT_READY` pulses produce no `dc_rd_data_valid`.
- Read burstcnt 0 → `DDRAM_BURSTCNT`=1, one valid word returned.
- Macro on, `WDOG_CYCLES`=16, data never returned → `err`=1 at cycle 16 of `RD_DATA`, state `IDLE`, `dc_wr_busy`=0.
